// File: rtl/seven_to_binary_capture.sv
// seven_to_binary_capture
// Watches a multiplexed, active-low seven-segment display bus and recovers the
// hex nibble shown on each digit. An {an,seg} word must stay stable, with
// exactly one anode low, for STABLE_COUNT consecutive edges before it is
// committed. This rejects scan transitions and glitches.
module seven_to_binary_capture #(
    parameter  int DIGITS       = 4,
    parameter  int STABLE_COUNT = 3,
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   nibbles,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  bad_pattern,
    output logic [IDX_W-1:0]      update_idx
);

    localparam int               SW       = DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    // True when exactly one active-low anode is asserted.
    function automatic logic onehot_low(input logic [DIGITS-1:0] a);
        return ($countones(~a) == 1);
    endfunction

    // Position of the (single) low anode bit.
    function automatic logic [IDX_W-1:0] low_index(input logic [DIGITS-1:0] a);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!a[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    // Inverse of the hex-to-seven-segment table: {hit, nibble}, seg is g..a.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0011000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0;
        endcase
    endfunction

    logic [SW-1:0]      w_in;
    logic [SW-1:0]      r_sample;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_match;
    logic               w_commit;
    logic [IDX_W-1:0]   w_idx;
    logic [4:0]         w_dec;
    logic               w_blank;
    logic [3:0]         r_nib [DIGITS];
    logic [DIGITS-1:0]  r_valid;
    logic               r_update;
    logic               r_bad;
    logic [IDX_W-1:0]   r_idx;

    assign w_in     = {an, seg};
    assign w_match  = (w_in == r_sample) && onehot_low(an);
    // The commit edge is the single edge where the count reaches its ceiling;
    // a saturated count never re-commits until the inputs change.
    assign w_commit = w_match && (r_cnt == CNT_LAST);
    assign w_idx    = low_index(r_sample[SW-1:7]);
    assign w_dec    = decode_seg(r_sample[6:0]);
    assign w_blank  = (r_sample[6:0] == 7'h7F);

    // Stability count: advance on a repeated valid scan, saturating, else clear.
    always_comb begin
        w_cnt_next = '0;
        if (w_match) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
        end
    end

    // Sample register and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '1;
            r_cnt    <= '0;
        end else begin
            r_sample <= w_in;
            r_cnt    <= w_cnt_next;
        end
    end

    // Commit a stable pattern to its digit and raise the matching event pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DIGITS; k++) r_nib[k] <= 4'h0;
            r_valid  <= '0;
            r_update <= 1'b0;
            r_bad    <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_update <= 1'b0;
            r_bad    <= 1'b0;
            if (w_commit) begin
                if (w_dec[4]) begin
                    r_nib[w_idx]   <= w_dec[3:0];
                    r_valid[w_idx] <= 1'b1;
                    if (!r_valid[w_idx] || (r_nib[w_idx] != w_dec[3:0])) begin
                        r_update <= 1'b1;
                        r_idx    <= w_idx;
                    end
                end else if (w_blank) begin
                    r_valid[w_idx] <= 1'b0;
                end else begin
                    r_bad <= 1'b1;
                    r_idx <= w_idx;
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_pack
        assign nibbles[4*g +: 4] = r_nib[g];
    end

    assign digit_valid = r_valid;
    assign update      = r_update;
    assign bad_pattern = r_bad;
    assign update_idx  = r_idx;

endmodule

// File: doc/seven_to_binary_capture.md
# seven_to_binary_capture

Display-bus capture block: samples a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and recovers the hex nibble shown on each digit. It is the inverse of the team's hex-to-seven-segment decoder. Use it as a loopback checker on the display path, or to read back what a scanned display is showing. A stability filter rejects scan transitions and glitches. Per-digit value registers, valid flags, and one-cycle event pulses feed downstream logic.

## Interface
- DIGITS, 4: number of multiplexed digits; 1 to 8.
- STABLE_COUNT, 3: consecutive matching samples required before a commit; 1 to 15.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- seg  in  7  active-low segment pattern, bit0 = a through bit6 = g.
- an  in  DIGITS  active-low digit enables; a valid scan has exactly one bit low.
- nibbles  out  4*DIGITS  recovered value; digit i is at [4i+3:4i].
- digit_valid  out  DIGITS  digit i holds a committed hex value.
- update  out  1  one-cycle pulse when a committed digit's value is new or changed.
- bad_pattern  out  1  one-cycle pulse when a stable pattern is neither a table entry nor blank.
- update_idx  out  max(1,clog2(DIGITS))  digit index for update or bad_pattern; holds its last value otherwise.

## Operation
- Decode table, seg value (bits g..a) to nibble:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Blank = 1111111.
- Sample register sample_q captures {an,seg} on every edge.
- Counter cnt (width fits STABLE_COUNT) updates each edge:
  - Incoming {an,seg} equals sample_q and an has exactly one low bit: cnt <= min(cnt+1, STABLE_COUNT).
  - Otherwise: cnt <= 0.
- Commit happens only on the edge where cnt goes from STABLE_COUNT-1 to STABLE_COUNT. Let i be the index of the low bit of sample_q.an.
  - Table hit:
    - nibbles[i] <= decoded value and digit_valid[i] <= 1.
    - update pulses with update_idx = i if digit_valid[i] was 0 or the value differs.
    - Same value re-committed: no pulse.
  - Blank: digit_valid[i] <= 0, nibbles[i] held, no pulse.
  - Any other pattern: bad_pattern pulses with update_idx = i; nibbles and digit_valid unchanged.
- While inputs stay stable, cnt saturates. No further commits happen until the inputs change and stabilise again.
- Zero anodes low, or more than one low: cnt held at 0 and no commit.
- Only one digit can commit per edge, so update and bad_pattern are mutually exclusive.

## Timing
- Reset values (reset high at an edge): sample_q = all ones, cnt = 0, nibbles = 0, digit_valid = 0, update = 0, bad_pattern = 0, update_idx = 0.
- Reset has priority over every other action.
- Latency: {an,seg} changes before edge E0 and is then held.
  - E0: sample_q loads the new value; cnt <= 0 on the mismatch.
  - Commit occurs at edge E(STABLE_COUNT).
  - Outputs and pulse are visible in the cycle after E(STABLE_COUNT).
- A change of any input bit before E(STABLE_COUNT) restarts the sequence from E0 with no commit.
- Reset mid-count discards the pending sample.
- After reset deasserts, the first edge always sees a mismatch, because sample_q is all ones and that pattern is an invalid scan. The first commit is therefore STABLE_COUNT+1 edges after the last reset edge.
- Pulses last exactly one cycle. Back-to-back commits on different digits are at least STABLE_COUNT+1 cycles apart.

## Test plan
- Reset: apply reset for 2 cycles with random inputs -> nibbles = 0, digit_valid = 0, update = 0, bad_pattern = 0.
- Single digit, STABLE_COUNT=3: an = 1110, seg = 0100100 held 6 cycles -> at E3, nibbles[3:0] = 2, digit_valid = 0001, update pulses once with update_idx = 0; no re-pulse while held.
- Glitch rejection: an = 1101, seg = 0110000 held 2 cycles, then seg = 0011001 held 5 cycles -> no commit of 3; digit 1 commits 4 at E3 of the second value.
- Full scan: digits 0..3 show A, b, C, d, each held 4 cycles, repeated twice -> nibbles = 16'hDCBA, digit_valid = 1111; 4 update pulses on the first pass, none on the second pass.
- Bad and blank patterns:
  - an = 1011, seg = 1010101 -> bad_pattern pulse, update_idx = 2, digit 2 unchanged.
  - an = 1110, seg = 1111111 -> digit_valid[0] = 0, no pulses.
- Illegal scan and reset mid-count: an = 1100 with a valid seg held 10 cycles -> no commit. Then a valid digit with reset asserted at E2 -> no commit; the first commit lands STABLE_COUNT+1 edges after reset.
